down_counter_timer: RTL and testbench

Loadable down-counter and one-shot timer. It is the counterpart to the team's 4-bit enable-driven up-counter: it counts down from a loaded value toward zero instead of up from zero. It emits a single-cycle terminal pulse on reaching zero. It sits behind the tile wrapper, with load value, load, start and tick-enable driven from dedicated inputs and count/status driven to dedicated outputs.

---
 rtl/down_counter_timer_pkg.sv | 9 +
 rtl/down_counter_timer_if.sv | 13 +
 rtl/down_counter_timer.sv | 50 +++++
 tb/tb_down_counter_timer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/down_counter_timer_pkg.sv
// down_counter_timer_pkg: shared state encoding and default width for the down-counter timer
package down_counter_timer_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control inputs and count/status outputs of the down-counter timer
interface down_counter_timer_if #(parameter int WIDTH = down_counter_timer_pkg::DEFAULT_WIDTH);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;
  modport master (output load, load_val, start, enable, input count, busy, done, zero);
  modport slave  (input load, load_val, start, enable, output count, busy, done, zero);
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable one-shot down-counter, periodic reload when DOWN_COUNTER_TIMER_AUTO_RELOAD_EN is defined
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  down_counter_timer_if.slave bus
);
  logic [WIDTH-1:0] r_count;
  state_t           r_state;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  // reload value tracks every load so DONE can restart the period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_reload <= '0;
    else if (bus.load) r_reload <= bus.load_val;
`endif
  // load aborts everything; otherwise IDLE waits for start, RUN ticks down on enable, DONE lasts one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_count <= '0;
      r_state <= IDLE;
    end else if (bus.load) begin
      r_count <= bus.load_val;
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (bus.start) r_state <= (r_count == '0) ? DONE : RUN;
        RUN: if (bus.enable) begin
          r_count <= r_count - 1'b1;
          if (r_count == WIDTH'(1)) r_state <= DONE;
        end
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        DONE: if (r_reload != '0) begin
          r_count <= r_reload;
          r_state <= RUN;
        end else r_state <= IDLE;
`else
        DONE: r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  assign bus.count = r_count;
  assign bus.busy  = (r_state == RUN);
  assign bus.done  = (r_state == DONE);
  assign bus.zero  = (r_count == '0);
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed test-plan sequences plus random traffic against a behavioural model
module tb_down_counter_timer;
  import down_counter_timer_pkg::*;
  localparam int W = DEFAULT_WIDTH;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int m_cnt = 0;
  int m_rel = 0;
  bit m_run = 0;
  bit m_done = 0;
  int pulses;
  down_counter_timer_if #(.WIDTH(W)) bus();
  down_counter_timer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("count", int'(bus.count), m_cnt);
    chk("busy", int'(bus.busy), int'(m_run));
    chk("done", int'(bus.done), int'(m_done));
    chk("zero", int'(bus.zero), int'(m_cnt == 0));
  endtask
  task automatic model_reset();
    m_cnt = 0;
    m_rel = 0;
    m_run = 0;
    m_done = 0;
  endtask
  task automatic step(input bit l, input int v, input bit s, input bit e);
    bus.load = l;
    bus.load_val = W'(v);
    bus.start = s;
    bus.enable = e;
    @(posedge clk);
    if (l) begin
      m_cnt = v;
      m_rel = v;
      m_run = 0;
      m_done = 0;
    end else if (m_done) begin
      m_done = 0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      if (m_rel != 0) begin
        m_cnt = m_rel;
        m_run = 1;
      end
`endif
    end else if (m_run) begin
      if (e) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_run = 0;
          m_done = 1;
        end
      end
    end else if (s) begin
      if (m_cnt == 0) m_done = 1;
      else m_run = 1;
    end
    #1 check_all();
  endtask
  task automatic async_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #2 rst_n = 1'b1;
  endtask
  initial begin
    bus.load = 0;
    bus.load_val = '0;
    bus.start = 0;
    bus.enable = 0;
    #1 check_all();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1 check_all();
    step(1, 5, 0, 0);
    step(0, 0, 1, 1);
    chk("start_busy", int'(bus.busy), 1);
    for (int i = 4; i >= 0; i--) begin
      step(0, 0, 0, 1);
      chk("basic_count", int'(bus.count), i);
      chk("basic_done", int'(bus.done), int'(i == 0));
    end
    step(0, 0, 0, 1);
`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    chk("basic_after_done", int'(bus.done), 0);
    chk("basic_idle", int'(bus.busy), 0);
`endif
    step(1, 3, 0, 0);
    step(0, 0, 1, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, (i % 2) == 0);
      pulses += int'(bus.done);
    end
    chk("gap_count", int'(bus.count), 0);
    chk("gap_pulses", pulses, 1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("zero_start_done", int'(bus.done), 1);
    chk("zero_start_busy", int'(bus.busy), 0);
    step(0, 0, 0, 0);
    step(1, 6, 1, 1);
    chk("collide_count", int'(bus.count), 6);
    chk("collide_busy", int'(bus.busy), 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(1, 9, 0, 1);
    chk("abort_count", int'(bus.count), 9);
    chk("abort_busy", int'(bus.busy), 0);
    async_reset();
    chk("async_count", int'(bus.count), 0);
    chk("async_zero", int'(bus.zero), 1);
    step(1, 7, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("midrun_count", int'(bus.count), 5);
    async_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1);
      pulses += int'(bus.done);
    end
    chk("midrun_no_done", pulses, 0);
    chk("midrun_idle", int'(bus.busy), 0);
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    step(1, 2, 0, 0);
    step(0, 0, 1, 1);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 0, 1);
      chk("reload_period", int'(bus.done), int'((i % 3) == 2));
    end
    step(1, 0, 0, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      pulses += int'(bus.done);
    end
    chk("reload_stop", pulses, 0);
`endif
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
